// File: rtl/dm_ctrl.sv
// Data-memory controller: turns MEM-stage strobes into a req/ack backing-memory transaction.
// Optional one-entry posted write buffer enabled by defining DM_CTRL_WBUF_EN.
module dm_ctrl #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dm_re,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_in,
   output logic [DW-1:0] dm_out,
   output logic          stall,
   output logic          bus_err,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            mem_req_q, mem_req_d;
   logic            mem_wr_q, mem_wr_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]   dm_out_q, dm_out_d;
   logic            bus_err_q, bus_err_d;
   logic            access;
   logic            to_hit;
   logic            finish_idle;
`ifdef DM_CTRL_WBUF_EN
   logic            drain_q, drain_d;
`endif

   assign access = dm_re | dm_we;
   assign to_hit = (TIMEOUT != 0) && ((cnt_q + CntW'(1)) == CntLimit);

`ifdef DM_CTRL_WBUF_EN
   // A drained posted write has no pipeline op waiting on it, so it skips DONE.
   assign finish_idle = drain_q;
`else
   assign finish_idle = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      dm_out_d    = dm_out_q;
      bus_err_d   = bus_err_q;
`ifdef DM_CTRL_WBUF_EN
      drain_d     = drain_q;
`endif
      case (state_q)
         StIdle: begin
            if (access) begin
               state_d     = StBusy;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_wr_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_in;
`ifdef DM_CTRL_WBUF_EN
               drain_d     = dm_we;
`endif
            end
         end
         StBusy: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               if (!mem_wr_q) dm_out_d = mem_rdata;
               state_d = finish_idle ? StIdle : StDone;
`ifdef DM_CTRL_WBUF_EN
               drain_d = 1'b0;
`endif
            end else if (to_hit) begin
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               if (!mem_wr_q) dm_out_d = '1;
               state_d = finish_idle ? StIdle : StDone;
`ifdef DM_CTRL_WBUF_EN
               drain_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      if (!rst) begin
`ifdef DM_CTRL_WBUF_EN
         // Writes post into the buffer; only reads hold the pipe from IDLE.
         if (state_q == StIdle) stall = dm_re & ~dm_we;
         else if (state_q == StBusy) stall = drain_q ? access : 1'b1;
`else
         if (state_q == StIdle) stall = access;
         else if (state_q == StBusy) stall = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         dm_out_q    <= '0;
         bus_err_q   <= 1'b0;
`ifdef DM_CTRL_WBUF_EN
         drain_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         dm_out_q    <= dm_out_d;
         bus_err_q   <= bus_err_d;
`ifdef DM_CTRL_WBUF_EN
         drain_q     <= drain_d;
`endif
      end
   end

   assign dm_out    = dm_out_q;
   assign bus_err   = bus_err_q;
   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: scoreboard of expected dm_out per completed access,
// plus direct checks of the memory-side handshake, timeout and reset behaviour.
module tb_dm_ctrl;

   localparam int To = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        dm_re, dm_we;
   logic [15:0] dm_addr, dm_in, dm_out;
   logic        stall, bus_err, mem_req, mem_wr, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] sb_q[$];
   logic [15:0] mem_model [logic [15:0]];
   logic [15:0] last_rd;
   logic [15:0] exp_v;
   logic        prev_stall = 1'b0;

   always #5 clk = ~clk;

   dm_ctrl #(
      .DW      (16),
      .AW      (16),
      .TIMEOUT (To)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .dm_re     (dm_re),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_in     (dm_in),
      .dm_out    (dm_out),
      .stall     (stall),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A completed access is the cycle where stall falls; pop its expected dm_out.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && !stall) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 32'd1, 32'd0);
            end else begin
               exp_v = sb_q.pop_front();
               check("sb_dm_out", {16'd0, dm_out}, {16'd0, exp_v});
            end
         end
         prev_stall = stall;
      end
   end

   task automatic do_access(input string tag, input logic re, input logic we,
                            input logic [15:0] addr, input logic [15:0] din,
                            input int ack_wait, input logic [15:0] rdata, input int exp_stall);
      int stalls;
      int busy;
      stalls = 0;
      busy   = 0;
      if (!we) begin
         mem_model[addr] = rdata;
         last_rd = (ack_wait >= To) ? 16'hFFFF : rdata;
      end
      sb_q.push_back(last_rd);
      step();
      dm_re = re; dm_we = we; dm_addr = addr; dm_in = din; mem_ack = 1'b0;
      #3;
      while (stall && stalls < 40) begin
         stalls++;
         step();
         mem_ack = 1'b0;
         dm_addr = ~addr;
         dm_in   = ~din;
         if (mem_req) begin
            check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
            check({tag, "_wr"}, {31'd0, mem_wr}, {31'd0, we});
            if (we) check({tag, "_wdata"}, {16'd0, mem_wdata}, {16'd0, din});
            if (busy == ack_wait) begin
               mem_ack = 1'b1;
               if (mem_wr) mem_model[mem_addr] = mem_wdata;
               else mem_rdata = mem_model[mem_addr];
            end
            busy++;
         end
         #3;
      end
      check({tag, "_stall"}, stalls, exp_stall);
      check({tag, "_busy"}, busy, (ack_wait >= To) ? To : ack_wait + 1);
      check({tag, "_req_off"}, {31'd0, mem_req}, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         dm_re = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
         #3;
         check("idle_stall", {31'd0, stall}, 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; dm_re = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040; dm_in = '0;
      mem_ack = 1'b0; mem_rdata = '0; last_rd = '0;
      step(); #3;
      check("rst_stall", {31'd0, stall}, 32'd0);
      step();
      check("rst_dm_out", {16'd0, dm_out}, 32'd0);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_addr", {16'd0, mem_addr}, 32'd0);
      check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      step();
      rst = 1'b0; dm_re = 1'b0;
      #3;
      check("post_rst_stall", {31'd0, stall}, 32'd0);

      do_access("lw", 1'b1, 1'b0, 16'h0040, 16'h0, 0, 16'hBEEF, 2);
      check("lw_out", {16'd0, dm_out}, 32'h0000BEEF);
      idle(1);
`ifndef DM_CTRL_WBUF_EN
      do_access("sw", 1'b0, 1'b1, 16'h0010, 16'h1234, 3, 16'h0, 5);
      check("sw_out", {16'd0, dm_out}, 32'h0000BEEF);
      idle(1);
      do_access("rw", 1'b1, 1'b1, 16'h0030, 16'hAAAA, 1, 16'h0, 3);
      check("rw_out", {16'd0, dm_out}, 32'h0000BEEF);
      idle(1);
`endif
      do_access("lw1", 1'b1, 1'b0, 16'h0100, 16'h0, 0, 16'h0001, 2);
      check("lw1_out", {16'd0, dm_out}, 32'h1);
      do_access("lw2", 1'b1, 1'b0, 16'h0102, 16'h0, 1, 16'h0002, 3);
      check("lw2_out", {16'd0, dm_out}, 32'h2);
      idle(1);

      // Stray ack while idle must not disturb anything.
      step();
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      #3;
      check("stray_stall", {31'd0, stall}, 32'd0);
      step();
      mem_ack = 1'b0;
      check("stray_out", {16'd0, dm_out}, 32'h2);
      check("stray_req", {31'd0, mem_req}, 32'd0);

      do_access("to", 1'b1, 1'b0, 16'h0050, 16'h0, 100, 16'h0, 1 + To);
      check("to_err", {31'd0, bus_err}, 32'd1);
      check("to_out", {16'd0, dm_out}, 32'h0000FFFF);
      idle(1);
      do_access("lw3", 1'b1, 1'b0, 16'h0060, 16'h0, 0, 16'h0A0A, 2);
      check("sticky_err", {31'd0, bus_err}, 32'd1);

      // Reset in the middle of a read, followed by a late ack.
      mem_model[16'h0070] = 16'h7777;
      step();
      dm_re = 1'b1; dm_we = 1'b0; dm_addr = 16'h0070;
      #3;
      check("mid_stall0", {31'd0, stall}, 32'd1);
      step();
      check("mid_req", {31'd0, mem_req}, 32'd1);
      step();
      rst = 1'b1;
      #3;
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      step();
      rst = 1'b0; dm_re = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
      check("mid_req_off", {31'd0, mem_req}, 32'd0);
      check("mid_out", {16'd0, dm_out}, 32'd0);
      check("mid_err", {31'd0, bus_err}, 32'd0);
      #3;
      check("late_ack_stall", {31'd0, stall}, 32'd0);
      step();
      mem_ack = 1'b0;
      check("late_ack_out", {16'd0, dm_out}, 32'd0);
      check("late_ack_req", {31'd0, mem_req}, 32'd0);
      last_rd = '0;

`ifdef DM_CTRL_WBUF_EN
      // Posted SW then LW of the same address: the read waits for the drain.
      step();
      dm_we = 1'b1; dm_re = 1'b0; dm_addr = 16'h0020; dm_in = 16'h5555;
      #3;
      check("wb_sw_stall", {31'd0, stall}, 32'd0);
      sb_q.push_back(16'h5555);
      step();
      dm_we = 1'b0; dm_re = 1'b1; dm_addr = 16'h0020; dm_in = 16'h0;
      check("wb_drain_req", {31'd0, mem_req}, 32'd1);
      check("wb_drain_wr", {31'd0, mem_wr}, 32'd1);
      check("wb_drain_data", {16'd0, mem_wdata}, 32'h5555);
      #3;
      check("wb_lw_stall0", {31'd0, stall}, 32'd1);
      step();
      mem_ack = 1'b1;
      mem_model[mem_addr] = mem_wdata;
      #3;
      check("wb_lw_stall1", {31'd0, stall}, 32'd1);
      step();
      mem_ack = 1'b0;
      check("wb_idle_req", {31'd0, mem_req}, 32'd0);
      #3;
      check("wb_lw_stall2", {31'd0, stall}, 32'd1);
      step();
      check("wb_rd_req", {31'd0, mem_req}, 32'd1);
      check("wb_rd_wr", {31'd0, mem_wr}, 32'd0);
      check("wb_rd_addr", {16'd0, mem_addr}, 32'h20);
      mem_ack = 1'b1;
      mem_rdata = mem_model[16'h0020];
      step();
      mem_ack = 1'b0;
      #3;
      check("wb_done_stall", {31'd0, stall}, 32'd0);
      check("wb_out", {16'd0, dm_out}, 32'h5555);
      last_rd = 16'h5555;
`endif

      idle(2);
      check("sb_left", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
